opnd_shift_reg: RTL and testbench
=================================

# opnd_shift_reg

Parametrised operand register for the shift-add multiplier datapath. Behaviour:
- Parallel load, as in the current 16-bit load register.
- Synchronous clear.
- Sequenced multi-cycle shift: left or right, serial fill bit, programmable shift count.
- Completion flag.

The multiplier controller uses it to hold the multiplier and partial-product operands. It starts a shift run and waits for `done` instead of counting cycles itself.

## Interface
Parameters:
- `WIDTH`, 16, register width in bits (≥2).
- `CW`, `$clog2(WIDTH+1)`, shift-count width (localparam, derived).

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `clr`  in  1  synchronous clear of `X`, aborts any run.
- `load`  in  1  parallel load request.
- `data`  in  WIDTH  parallel load value.
- `start`  in  1  begin shift run.
- `dir`  in  1  0 = shift right (toward LSB), 1 = shift left; sampled with `start`.
- `shamt`  in  CW  number of single-bit shifts; sampled with `start`.
- `ser_in`  in  1  fill bit entering vacated end, sampled every shift cycle.
- `X`  out  WIDTH  register contents.
- `ser_out`  out  1  registered bit shifted out on the most recent shift.
- `busy`  out  1  high while in SHIFT.
- `done`  out  1  one-cycle pulse after the last shift of a run.

## Operation
States:
- IDLE: accepts `load`/`start`.
- SHIFT: one shift per cycle.
- DONE: one cycle, `done`=1, then IDLE.

Priority each edge: `clr` > `load` > `start`.
- `clr`: `X`←0, `ser_out`←0, state←IDLE, count←0. `done` is not asserted.
- `load` in IDLE or DONE: `X`←`data`. Any `start` in the same cycle is ignored.
- `load` in SHIFT is ignored.
- `start` in IDLE or DONE:
  - latch `dir`; count←`shamt`.
  - `shamt`≠0 → SHIFT; `shamt`=0 → DONE with no shift.
- `start` in SHIFT is ignored.
- SHIFT, each edge:
  - right: `X`←{`ser_in`, X[WIDTH-1:1]}, `ser_out`←X[0].
  - left: `X`←{X[WIDTH-2:0], `ser_in`}, `ser_out`←X[WIDTH-1].
  - count←count-1; when count was 1 → DONE.
- `shamt` may exceed WIDTH. The run still performs exactly `shamt` shifts, with no clamping.
- Outside SHIFT, `X` and `ser_out` hold unless loaded or cleared.

## Timing
- Reset values: `X`=0, `ser_out`=0, `busy`=0, `done`=0, state IDLE, count 0.
- `rst_n` low is effective immediately, including mid-run. No `done` follows.
- Load latency: `X` shows `data` after the sampling edge (1 cycle).
- Shift run, with `start` sampled at edge E0:
  - `busy` is high from after E0 until after edge E`shamt`.
  - shift k completes at edge Ek.
  - `done` is high for the cycle after E`shamt`.
- `shamt`=0: `done` is high for the cycle after E0; `busy` never rises.
- Back-to-back runs: `start` in the DONE cycle is accepted. This gives a continuous stream with a one-cycle gap.
- `busy` and `done` decode from state registers only. They are glitch-free and never high together.

## Structure
- Shared package `mult_pkg`: state encoding (`ST_IDLE`, `ST_SHIFT`, `ST_DONE`) and direction constants (`DIR_RIGHT`=0, `DIR_LEFT`=1).
- One sub-module, `shift_cnt`: CW-bit loadable down-counter.
  - Ports: `clk`, `rst_n`, `ld`, `d`, `dec`, `q`, `last` (`q`==1).
  - The FSM and data register stay in `opnd_shift_reg`.

## Test plan
All scenarios use WIDTH=16.
- Reset then load: `rst_n` pulse, then `load`, `data`=16'hA5C3 → `X`=0 during reset; `X`=16'hA5C3 one edge after load; `busy`=`done`=0.
- Right run: from 16'hA5C3, `start`, `dir`=0, `shamt`=4, `ser_in`=0 →
  - `busy` high 4 cycles; `ser_out` sequence 1,1,0,0.
  - `X`=16'h0A5C.
  - `done` high for exactly 1 cycle, then IDLE.
- Left run with fill: `X`=16'h8001, `dir`=1, `shamt`=1, `ser_in`=1 → `X`=16'h0003, `ser_out`=1, `done` pulse on the next cycle.
- Zero count and conflicts:
  - `shamt`=0 → `done` the cycle after `start`, `X` unchanged, `busy` stays 0.
  - `load` and `start` together in IDLE → load only.
  - `load`/`start` during SHIFT → ignored; run completes unchanged.
- Abort: `clr` at shift 2 of an 8-shift run → `X`=0, IDLE next cycle, no `done`.
  - Repeat with `rst_n` low mid-run → `X`=0 immediately; outputs at reset values.
- Back-to-back: `start` asserted in the DONE cycle with `shamt`=3 → second run accepted; total shifts 4+3 from 16'hA5C3 right, `ser_in`=0 → `X`=16'h014B.

Source files
------------

// File: rtl/mult_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : mult_pkg                                                   |
// | Shared state encoding and shift-direction constants for the          |
// | shift-add multiplier datapath.                                       |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
package mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/shift_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : shift_cnt                                                  |
// | Loadable down-counter holding the remaining shifts of a run.         |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module shift_cnt #(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld,
  input  logic [CW-1:0] d,
  input  logic          dec,
  output logic [CW-1:0] q,
  output logic          last
);

  logic [CW-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (ld) begin
      r_q <= d;
    end else if (dec) begin
      r_q <= r_q - CW'(1);
    end
  end

  assign q    = r_q;
  assign last = (r_q == CW'(1));

endmodule
`default_nettype wire

// File: rtl/opnd_shift_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : opnd_shift_reg                                             |
// | Operand register: parallel load, clear, sequenced multi-bit shift    |
// | with serial fill and a one-cycle completion pulse.                   |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module opnd_shift_reg
  import mult_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             start,
  input  logic             dir,
  input  logic [CW-1:0]    shamt,
  input  logic             ser_in,
  output logic [WIDTH-1:0] X,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_dir;
  logic [WIDTH-1:0]  r_x;
  logic              r_ser_out;

  logic              w_start_acc;
  logic              w_cnt_ld;
  logic              w_cnt_dec;
  logic              w_cnt_last;
  logic [CW-1:0]     w_cnt_d;
  logic [CW-1:0]     w_cnt_q;

  // load beats start; nothing new is accepted while a run is in flight
  assign w_start_acc = (r_state != ST_SHIFT) & start & ~load & ~clr;

  shift_cnt #(
    .CW (CW)
  ) u_shift_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .ld    (w_cnt_ld),
    .d     (w_cnt_d),
    .dec   (w_cnt_dec),
    .q     (w_cnt_q),
    .last  (w_cnt_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_ld    = 1'b0;
    w_cnt_d     = '0;
    w_cnt_dec   = 1'b0;
    if (clr) begin
      w_state_nxt = ST_IDLE;
      w_cnt_ld    = 1'b1;
    end else begin
      case (r_state)
        ST_SHIFT: begin
          w_cnt_dec = (w_cnt_q != '0);
          // a zero count here cannot occur normally; leave rather than hang
          if (w_cnt_last || (w_cnt_q == '0)) begin
            w_state_nxt = ST_DONE;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          if (w_start_acc) begin
            w_cnt_ld    = 1'b1;
            w_cnt_d     = shamt;
            w_state_nxt = (shamt != '0) ? ST_SHIFT : ST_DONE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x       <= '0;
      r_ser_out <= 1'b0;
      r_dir     <= DIR_RIGHT;
    end else if (clr) begin
      r_x       <= '0;
      r_ser_out <= 1'b0;
    end else if (r_state == ST_SHIFT) begin
      if (r_dir == DIR_LEFT) begin
        r_x       <= {r_x[WIDTH-2:0], ser_in};
        r_ser_out <= r_x[WIDTH-1];
      end else begin
        r_x       <= {ser_in, r_x[WIDTH-1:1]};
        r_ser_out <= r_x[0];
      end
    end else if (load) begin
      r_x <= data;
    end else if (w_start_acc) begin
      r_dir <= dir;
    end
  end

  assign X       = r_x;
  assign ser_out = r_ser_out;
  assign busy    = (r_state == ST_SHIFT);
  assign done    = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_opnd_shift_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_opnd_shift_reg                                          |
// | Directed plus randomized bench for opnd_shift_reg with a reference.  |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module tb_opnd_shift_reg;

  localparam int WIDTH = 16;
  localparam int CW    = $clog2(WIDTH + 1);

  logic             clk    = 1'b0;
  logic             rst_n  = 1'b0;
  logic             clr    = 1'b0;
  logic             load   = 1'b0;
  logic [WIDTH-1:0] data   = '0;
  logic             start  = 1'b0;
  logic             dir    = 1'b0;
  logic [CW-1:0]    shamt  = '0;
  logic             ser_in = 1'b0;
  logic [WIDTH-1:0] X;
  logic             ser_out;
  logic             busy;
  logic             done;

  opnd_shift_reg #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .load    (load),
    .data    (data),
    .start   (start),
    .dir     (dir),
    .shamt   (shamt),
    .ser_in  (ser_in),
    .X       (X),
    .ser_out (ser_out),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // reference: register value, last shifted-out bit, shifts still owed
  logic [WIDTH-1:0] m_x;
  logic             m_so;
  int               m_rem;
  logic             m_dir;
  logic             m_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_x = '0; m_so = 1'b0; m_rem = 0; m_dir = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_step();
    if (clr) begin
      m_x = '0; m_so = 1'b0; m_rem = 0; m_done = 1'b0;
    end else if (m_rem > 0) begin
      if (m_dir) begin
        m_so = (m_x >> (WIDTH - 1)) & 1'b1;
        m_x  = (m_x << 1) | WIDTH'(ser_in);
      end else begin
        m_so = m_x & 1'b1;
        m_x  = (m_x >> 1) | (WIDTH'(ser_in) << (WIDTH - 1));
      end
      m_rem  = m_rem - 1;
      m_done = (m_rem == 0);
    end else begin
      m_done = 1'b0;
      if (load) m_x = data;
      else if (start) begin
        m_dir  = dir;
        m_rem  = int'(shamt);
        m_done = (shamt == 0);
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".X"}, X, m_x);
    chk({tag, ".ser_out"}, ser_out, m_so);
    chk({tag, ".busy"}, busy, (m_rem > 0));
    chk({tag, ".done"}, done, m_done);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic quiet();
    clr = 1'b0; load = 1'b0; start = 1'b0;
  endtask

  task automatic do_load(input logic [WIDTH-1:0] v);
    load = 1'b1; data = v;
    tick("load");
    load = 1'b0;
  endtask

  task automatic do_start(input logic d, input int n, input logic fill);
    start = 1'b1; dir = d; shamt = CW'(n); ser_in = fill;
  endtask

  initial begin
    model_reset();

    // reset then load
    @(posedge clk); #1;
    chk("rst.X", X, 0);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    rst_n = 1'b1;
    do_load(16'hA5C3);
    chk("ld.X", X, 16'hA5C3);

    // right run of 4
    do_start(1'b0, 4, 1'b0);
    tick("r4.e0");
    chk("r4.busy0", busy, 1);
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick("r4.sh");
      chk("r4.so", ser_out, (k < 2) ? 1 : 0);
    end
    chk("r4.X", X, 16'h0A5C);
    chk("r4.done", done, 1);
    chk("r4.busy", busy, 0);
    tick("r4.after");
    chk("r4.done_gone", done, 0);

    // left run of 1 with fill
    do_load(16'h8001);
    do_start(1'b1, 1, 1'b1);
    tick("l1.e0");
    start = 1'b0;
    tick("l1.e1");
    chk("l1.X", X, 16'h0003);
    chk("l1.so", ser_out, 1);
    chk("l1.done", done, 1);
    tick("l1.after");

    // zero count
    do_start(1'b0, 0, 1'b0);
    tick("z.e0");
    chk("z.done", done, 1);
    chk("z.busy", busy, 0);
    chk("z.X", X, 16'h0003);
    start = 1'b0;
    tick("z.after");

    // load with start in IDLE: load only
    load = 1'b1; data = 16'h1234;
    do_start(1'b0, 3, 1'b0);
    tick("ls");
    chk("ls.X", X, 16'h1234);
    chk("ls.busy", busy, 0);
    quiet();

    // load/start during a run are ignored
    do_start(1'b0, 5, 1'b0);
    tick("ign.e0");
    load = 1'b1; data = 16'hFFFF; start = 1'b1; shamt = CW'(1);
    tick("ign.e1");
    quiet();
    for (int k = 0; k < 4; k++) tick("ign.sh");
    chk("ign.X", X, 16'h0091);
    chk("ign.done", done, 1);
    tick("ign.after");

    // clear aborts at shift 2
    do_load(16'hA5C3);
    do_start(1'b0, 8, 1'b0);
    tick("clr.e0");
    start = 1'b0;
    tick("clr.e1");
    clr = 1'b1;
    tick("clr.e2");
    chk("clr.X", X, 0);
    chk("clr.busy", busy, 0);
    clr = 1'b0;
    tick("clr.after");
    chk("clr.nodone", done, 0);

    // async reset mid-run
    do_load(16'hA5C3);
    do_start(1'b0, 8, 1'b0);
    tick("ar.e0");
    start = 1'b0;
    tick("ar.e1");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("ar.X", X, 0);
    check_all("ar");
    #1 rst_n = 1'b1;
    tick("ar.after");
    chk("ar.nodone", done, 0);

    // back-to-back: 4 then 3 shifts right
    do_load(16'hA5C3);
    do_start(1'b0, 4, 1'b0);
    tick("bb.e0");
    start = 1'b0;
    for (int k = 0; k < 4; k++) tick("bb.r1");
    chk("bb.done1", done, 1);
    do_start(1'b0, 3, 1'b0);
    tick("bb.e0b");
    chk("bb.busy2", busy, 1);
    start = 1'b0;
    for (int k = 0; k < 3; k++) tick("bb.r2");
    chk("bb.X", X, 16'h014B);
    chk("bb.done2", done, 1);
    tick("bb.after");

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      clr    = ($urandom_range(0, 39) == 0);
      load   = ($urandom_range(0, 7) == 0);
      start  = ($urandom_range(0, 4) == 0);
      dir    = 1'($urandom_range(0, 1));
      ser_in = 1'($urandom_range(0, 1));
      shamt  = CW'($urandom_range(0, 20));
      data   = WIDTH'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rnd.rst");
        #1 rst_n = 1'b1;
      end
      tick("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
